// File: rtl/path_meter_pkg.sv
// ---------------------------------------------------------------------------
// path_meter_pkg
// Shared definitions for the path delay meter:
//   - state_e   : controller FSM state encoding
//   - DEF_*     : default values for the counter width and synchronizer depth
//   - sum_width : width of an accumulated sum over a run of trials
// ---------------------------------------------------------------------------
package path_meter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_LAUNCH_R = 3'd2,
      ST_WAIT_R   = 3'd3,
      ST_LAUNCH_F = 3'd4,
      ST_WAIT_F   = 3'd5,
      ST_NEXT     = 3'd6,
      ST_DONE     = 3'd7
   } state_e;

   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   // Each count is bounded by the timeout, so log2(trials) extra bits make
   // the accumulated sum overflow-free.
   function automatic int sum_width(input int cnt_w, input int trials);
      return cnt_w + $clog2(trials);
   endfunction

endpackage

// File: rtl/path_sync.sv
// ---------------------------------------------------------------------------
// path_sync
// Multi-flop synchronizer bringing the asynchronous delay-chain output into
// the clk domain.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears every stage)
//   d_in   in   asynchronous input
//   q_out  out  synchronized output (last stage)
// ---------------------------------------------------------------------------
module path_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic q_out
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Next value of the chain: shift the new sample in at bit 0.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_in};
   end

   // Synchronizer flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// ---------------------------------------------------------------------------
// path_delay_meter
// Launch/capture controller around a delay chain under test. For each trial
// it holds the chain input low, launches a rising edge, counts clk cycles
// until the synchronized output follows, then does the same for a falling
// edge. Per-trial and accumulated counts are reported for comparison with a
// golden value.
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle pulse, begins a run (ignored while busy)
//   path_input   out  drives the delay chain input (registered)
//   path_result  in   delay chain output, asynchronous to clk
//   busy         out  high from accepted start until done
//   done         out  one-cycle pulse at end of run
//   timeout_err  out  set for the run if a transition was lost
//   rise_cycles  out  last rise count
//   fall_cycles  out  last fall count
//   rise_sum     out  sum of rise counts over the run
//   fall_sum     out  sum of fall counts over the run
// A count equals the clk edges from the launch edge to the edge where the
// synchronized output first shows the new level, so a zero-delay path reads
// SYNC_STAGES.
// ---------------------------------------------------------------------------
module path_delay_meter
   import path_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned TRIALS      = 8,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned SETTLE_CYC  = 64,
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      start,
   output logic                                      path_input,
   input  logic                                      path_result,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      timeout_err,
   output logic [CNT_W-1:0]                          rise_cycles,
   output logic [CNT_W-1:0]                          fall_cycles,
   output logic [sum_width(CNT_W, TRIALS)-1:0]       rise_sum,
   output logic [sum_width(CNT_W, TRIALS)-1:0]       fall_sum
);

   localparam int unsigned SUM_W = sum_width(CNT_W, TRIALS);
   localparam int unsigned IDX_W = $clog2(TRIALS) + 1;
   localparam int unsigned SET_W = $clog2(SETTLE_CYC) + 1;

   localparam logic [CNT_W-1:0] TIMEOUT_V   = CNT_W'(TIMEOUT_CYC);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0] TRIALS_V    = IDX_W'(TRIALS);

   logic res_s;

   state_e             state_q,       state_d;
   logic [CNT_W-1:0]   cnt_q,         cnt_d;
   logic [SET_W-1:0]   settle_q,      settle_d;
   logic [IDX_W-1:0]   idx_q,         idx_d;
   logic               path_input_q,  path_input_d;
   logic               busy_q,        busy_d;
   logic               done_q,        done_d;
   logic               timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]   rise_cycles_q, rise_cycles_d;
   logic [CNT_W-1:0]   fall_cycles_q, fall_cycles_d;
   logic [SUM_W-1:0]   rise_sum_q,    rise_sum_d;
   logic [SUM_W-1:0]   fall_sum_q,    fall_sum_d;

   path_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (path_result),
      .q_out (res_s)
   );

   // Next-state and next-output computation for the launch/capture FSM.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      settle_d      = settle_q;
      idx_d         = idx_q;
      path_input_d  = path_input_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;
      rise_cycles_d = rise_cycles_q;
      fall_cycles_d = fall_cycles_q;
      rise_sum_d    = rise_sum_q;
      fall_sum_d    = fall_sum_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rise_sum_d    = '0;
               fall_sum_d    = '0;
               timeout_err_d = 1'b0;
               idx_d         = '0;
               settle_d      = '0;
               busy_d        = 1'b1;
               state_d       = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SETTLE: begin
            path_input_d = 1'b0;
            if (settle_q == SETTLE_LAST) begin
               // Output already high with input held low: path is stuck or
               // far too slow, so abort without launching.
               if (res_s) begin
                  timeout_err_d = 1'b1;
                  busy_d        = 1'b0;
                  done_d        = 1'b1;
                  state_d       = ST_DONE;
               end else begin
                  state_d = ST_LAUNCH_R;
               end
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end

         ST_LAUNCH_R: begin
            path_input_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_WAIT_R;
         end

         ST_WAIT_R: begin
            if (res_s) begin
               rise_cycles_d = cnt_q;
               rise_sum_d    = rise_sum_q + SUM_W'(cnt_q);
               state_d       = ST_LAUNCH_F;
            end else if (cnt_q == TIMEOUT_V) begin
               rise_cycles_d = TIMEOUT_V;
               timeout_err_d = 1'b1;
               path_input_d  = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_LAUNCH_F: begin
            path_input_d = 1'b0;
            cnt_d        = '0;
            state_d      = ST_WAIT_F;
         end

         ST_WAIT_F: begin
            if (!res_s) begin
               fall_cycles_d = cnt_q;
               fall_sum_d    = fall_sum_q + SUM_W'(cnt_q);
               state_d       = ST_NEXT;
            end else if (cnt_q == TIMEOUT_V) begin
               fall_cycles_d = TIMEOUT_V;
               timeout_err_d = 1'b1;
               path_input_d  = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_NEXT: begin
            idx_d = idx_q + IDX_W'(1);
            if ((idx_q + IDX_W'(1)) == TRIALS_V) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               settle_d = '0;
               state_d  = ST_SETTLE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            path_input_d = 1'b0;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         settle_q      <= '0;
         idx_q         <= '0;
         path_input_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         rise_cycles_q <= '0;
         fall_cycles_q <= '0;
         rise_sum_q    <= '0;
         fall_sum_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         settle_q      <= settle_d;
         idx_q         <= idx_d;
         path_input_q  <= path_input_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         rise_cycles_q <= rise_cycles_d;
         fall_cycles_q <= fall_cycles_d;
         rise_sum_q    <= rise_sum_d;
         fall_sum_q    <= fall_sum_d;
      end
   end

   assign path_input  = path_input_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;
   assign rise_cycles = rise_cycles_q;
   assign fall_cycles = fall_cycles_q;
   assign rise_sum    = rise_sum_q;
   assign fall_sum    = fall_sum_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// ---------------------------------------------------------------------------
// tb_path_delay_meter
// Directed bench for path_delay_meter with a behavioural delay chain model
// (loopback, fixed delay, stuck-at-0/1, asymmetric rise/fall delay).
// ---------------------------------------------------------------------------
module tb_path_delay_meter;

   localparam int CNT_W = 16;
   localparam int SUM_W = 19;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             path_input;
   logic             path_result;
   logic             busy;
   logic             done;
   logic             timeout_err;
   logic [CNT_W-1:0] rise_cycles;
   logic [CNT_W-1:0] fall_cycles;
   logic [SUM_W-1:0] rise_sum;
   logic [SUM_W-1:0] fall_sum;

   // 0 loopback, 1 delay 5, 2 stuck 0, 3 stuck 1, 4 rise 3 / fall 9
   int               mode = 0;
   logic [15:0]      dly_sr = 16'h0000;

   int               n_checks = 0;
   int               n_pass = 0;
   int               busy_cnt = 0;
   int               done_cnt = 0;
   int               pin_cnt = 0;
   int               busy_run;
   int               done_run;
   int               pin_run;

   path_delay_meter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .path_input  (path_input),
      .path_result (path_result),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .rise_cycles (rise_cycles),
      .fall_cycles (fall_cycles),
      .rise_sum    (rise_sum),
      .fall_sum    (fall_sum)
   );

   always #5 clk = ~clk;

   // Delay chain model: dly_sr[k] is path_input delayed by k+1 clk cycles.
   always @(posedge clk) dly_sr <= {dly_sr[14:0], path_input};

   always_comb begin
      case (mode)
         0:       path_result = path_input;
         1:       path_result = dly_sr[4];
         2:       path_result = 1'b0;
         3:       path_result = 1'b1;
         4:       path_result = dly_sr[2] | dly_sr[8];
         default: path_result = path_input;
      endcase
   end

   // Free-running activity counters sampled away from the active edge.
   always @(negedge clk) begin
      if (busy)       busy_cnt <= busy_cnt + 1;
      if (done)       done_cnt <= done_cnt + 1;
      if (path_input) pin_cnt  <= pin_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Start a run and wait (bounded) for done; optionally re-pulse start mid-run.
   task automatic run(input int budget, input int extra_at);
      int  b0, d0, p0;
      bit  got;
      b0  = busy_cnt;
      d0  = done_cnt;
      p0  = pin_cnt;
      got = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         start = (i == extra_at);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      repeat (4) @(negedge clk);
      busy_run = busy_cnt - b0;
      done_run = done_cnt - d0;
      pin_run  = pin_cnt - p0;
      chk("done_pulses", 32'(done_run), 32'd1);
   endtask

   task automatic wait_pin(input logic lvl, input int budget);
      for (int i = 0; i < budget && path_input !== lvl; i++) @(negedge clk);
      chk("wait_path_input", 32'(path_input), 32'(lvl));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(busy),        32'd0);
      chk({tag, "_done"},  32'(done),        32'd0);
      chk({tag, "_pin"},   32'(path_input),  32'd0);
      chk({tag, "_terr"},  32'(timeout_err), 32'd0);
      chk({tag, "_rc"},    32'(rise_cycles), 32'd0);
      chk({tag, "_fc"},    32'(fall_cycles), 32'd0);
      chk({tag, "_rs"},    32'(rise_sum),    32'd0);
      chk({tag, "_fs"},    32'(fall_sum),    32'd0);
   endtask

   initial begin
      int d0;
      #1;
      chk_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Loopback: 2 cycles each way, trial = 64+1+3+1+3+1 = 73 busy cycles.
      mode = 0;
      run(2000, -1);
      chk("lb_rc",   32'(rise_cycles), 32'd2);
      chk("lb_fc",   32'(fall_cycles), 32'd2);
      chk("lb_rs",   32'(rise_sum),    32'd16);
      chk("lb_fs",   32'(fall_sum),    32'd16);
      chk("lb_terr", 32'(timeout_err), 32'd0);
      chk("lb_busy", 32'(busy_run),    32'd584);

      // Delay 5: count 7, trial = 64+1+8+1+8+1 = 83 busy cycles.
      mode = 1;
      run(2000, -1);
      chk("d5_rc",   32'(rise_cycles), 32'd7);
      chk("d5_fc",   32'(fall_cycles), 32'd7);
      chk("d5_rs",   32'(rise_sum),    32'd56);
      chk("d5_fs",   32'(fall_sum),    32'd56);
      chk("d5_terr", 32'(timeout_err), 32'd0);
      chk("d5_busy", 32'(busy_run),    32'd664);

      // Stuck at 0: rise times out after counter values 0..4095.
      mode = 2;
      run(6000, -1);
      chk("s0_rc",   32'(rise_cycles), 32'd4095);
      chk("s0_terr", 32'(timeout_err), 32'd1);
      chk("s0_pin",  32'(path_input),  32'd0);
      chk("s0_rs",   32'(rise_sum),    32'd0);
      chk("s0_busy", 32'(busy_run),    32'd4161);

      // Stuck at 1: settle check fails, no launch.
      mode = 3;
      run(500, -1);
      chk("s1_terr",   32'(timeout_err), 32'd1);
      chk("s1_busy",   32'(busy_run),    32'd64);
      chk("s1_launch", 32'(pin_run),     32'd0);
      chk("s1_fs",     32'(fall_sum),    32'd0);

      // Loopback with a start pulse while busy: ignored.
      mode = 0;
      run(2000, 100);
      chk("rs_rc",   32'(rise_cycles), 32'd2);
      chk("rs_rs",   32'(rise_sum),    32'd16);
      chk("rs_terr", 32'(timeout_err), 32'd0);
      chk("rs_busy", 32'(busy_run),    32'd584);

      // Reset during WAIT_F of the first trial.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_pin(1'b1, 200);
      wait_pin(1'b0, 50);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
      chk("midrst_idle",   32'(busy),          32'd0);
      run(2000, -1);
      chk("post_rc", 32'(rise_cycles), 32'd2);
      chk("post_fc", 32'(fall_cycles), 32'd2);
      chk("post_rs", 32'(rise_sum),    32'd16);
      chk("post_fs", 32'(fall_sum),    32'd16);

      // Asymmetric delay: rise 3 -> 5, fall 9 -> 11.
      mode = 4;
      run(2000, -1);
      chk("as_rc",   32'(rise_cycles), 32'd5);
      chk("as_fc",   32'(fall_cycles), 32'd11);
      chk("as_rs",   32'(rise_sum),    32'd40);
      chk("as_fs",   32'(fall_sum),    32'd88);
      chk("as_terr", 32'(timeout_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/path_delay_meter.md
Name: path_delay_meter

Overview:
- Launch/capture controller that sits directly around a delay-chain path under test.
- Drives the chain's input with a rising then a falling transition.
- Samples the chain's output through a synchronizer and counts clock cycles until each transition arrives.
- Repeats for a programmable number of trials and reports per-trial and accumulated rise/fall counts; deviations from a golden count flag a delay-altering Trojan.

Parameters:
CNT_W, 16, width of per-transition cycle counter
TRIALS, 8, launch/capture repetitions per start (power of two, ≥1)
SYNC_STAGES, 2, flops in capture synchronizer (≥2)
SETTLE_CYC, 64, idle cycles with path_input=0 before first launch of each trial
TIMEOUT_CYC, 4095, max count before a transition is declared lost (< 2^CNT_W)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins a measurement run
path_input  out  1  drives input of delay chain under test
path_result  in  1  output of delay chain (asynchronous to clk)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
timeout_err  out  1  sticky for run; set if any transition timed out
rise_cycles  out  CNT_W  last trial's rise count
fall_cycles  out  CNT_W  last trial's fall count
rise_sum  out  CNT_W+$clog2(TRIALS)  sum of rise counts over run
fall_sum  out  CNT_W+$clog2(TRIALS)  sum of fall counts over run

Behaviour:
- Reset (async, rst_n=0): all outputs 0, path_input=0, FSM=IDLE, counters and sync flops cleared.
- path_input is driven from a flop; no combinational path from start.
- Capture: path_result passes through SYNC_STAGES flops → res_s. Transitions are detected on res_s only.
- FSM states: IDLE, SETTLE, LAUNCH_R, WAIT_R, LAUNCH_F, WAIT_F, NEXT, DONE.
- IDLE: start=1 → clear sums, timeout_err, trial index; busy=1; go SETTLE. start while busy is ignored.
- SETTLE: path_input=0 for SETTLE_CYC cycles. At the end, if res_s=1 → set timeout_err and go DONE; else go LAUNCH_R.
- LAUNCH_R: path_input←1 at this edge; counter←0; go WAIT_R.
- WAIT_R: counter increments each cycle. On the first cycle with res_s=1, rise_cycles←counter and rise_sum+=counter; go LAUNCH_F. If counter reaches TIMEOUT_CYC first: rise_cycles←TIMEOUT_CYC, set timeout_err, path_input←0, go DONE.
- Count semantics: the value equals the number of clk edges from the launch edge to the edge at which res_s first reads the new level. A zero-delay path reports exactly SYNC_STAGES.
- LAUNCH_F / WAIT_F: mirror of the rise states with path_input←0, waiting for res_s=0, updating fall_cycles/fall_sum.
- NEXT: trial index+1. If the index equals TRIALS → DONE; else → SETTLE.
- DONE: busy=0, done=1 for one cycle; go IDLE. Results and timeout_err hold until the next accepted start.
- Sums cannot overflow: each count ≤ TIMEOUT_CYC, and the sum width adds $clog2(TRIALS) bits. Sums are unsigned.
- A glitch on res_s during WAIT is not filtered; the first matching level wins.
- Reset mid-run: immediate return to the reset values; path_input drops to 0; no done pulse.

Decomposition:
- Package path_meter_pkg: FSM state enum, default constants (CNT_W, SYNC_STAGES), sum-width function.
- Sub-module path_sync: parameterized SYNC_STAGES flop chain with async active-low reset.

Test Plan:
- Loopback (path_result=path_input), TRIALS=8 → rise_cycles=fall_cycles=2, rise_sum=fall_sum=16, timeout_err=0, one done pulse.
- Behavioral delay of 5 clk cycles on the path → rise_cycles=fall_cycles=7, sums=56; busy high for 8×(64+2+7+7+...) cycles, exact count checked.
- path_result tied 0 → WAIT_R times out: rise_cycles=4095, timeout_err=1, done pulses, path_input=0.
- path_result tied 1 → SETTLE check fails: timeout_err=1, done after 64 settle cycles, no launch.
- start pulsed again while busy → ignored; rst_n asserted during WAIT_F → all outputs 0 immediately, no done; a later start gives correct loopback results.
- Asymmetric delay (rise 3, fall 9 cycles) → rise_cycles=5, fall_cycles=11, rise_sum=40, fall_sum=88.
